// File: rtl/ltc_frame_aligner.sv
// rtl/ltc_frame_aligner.sv - LTC LVDS ADC frame aligner: bitslip search, lock confirm, lock monitor, test-pattern check.
module ltc_frame_aligner #(
  parameter int               N_CH          = 2,
  parameter int               S             = 8,
  parameter logic [S-1:0]     FRAME_PATTERN = 8'hF0,
  parameter logic [2*S-1:0]   TP            = 16'h3DDA,
  parameter int               SETTLE_CYCLES = 4,
  parameter int               MATCH_COUNT   = 16,
  parameter int               ERR_LIMIT     = 4,
  parameter bit               AUTO_RELOCK   = 1'b1
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    start,
  input  logic                    valid,
  input  logic [S-1:0]            frame_in,
  input  logic [N_CH*2*S-1:0]     data_in,
  input  logic                    tp_en,
  output logic                    bitslip,
  output logic                    locked,
  output logic                    fail,
  output logic [$clog2(S+1)-1:0]  slip_cnt,
  output logic [N_CH-1:0]         tp_ok,
  output logic [15:0]             err_cnt
);

  localparam int SCW = $clog2(S + 1);
  localparam int MCW = $clog2(MATCH_COUNT + 1);
  localparam int RCW = $clog2(ERR_LIMIT + 1);
  localparam int STW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  localparam logic [SCW-1:0] SLIP_MAX    = SCW'(S);
  localparam logic [MCW-1:0] MATCH_MAX   = MCW'(MATCH_COUNT);
  localparam logic [RCW-1:0] RUN_MAX     = RCW'(ERR_LIMIT);
  localparam logic [STW-1:0] SETTLE_INIT = STW'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SLIP   = 3'd2,
    SETTLE = 3'd3,
    VERIFY = 3'd4,
    LOCKED = 3'd5,
    FAIL   = 3'd6
  } state_t;

  state_t          state_q,  state_d;
  logic [SCW-1:0]  slip_q,   slip_d;
  logic [MCW-1:0]  match_q,  match_d;
  logic [RCW-1:0]  run_q,    run_d;
  logic [STW-1:0]  settle_q, settle_d;
  logic [15:0]     err_q,    err_d;
  logic [N_CH-1:0] tp_q,     tp_d;

  logic frame_ok;
  assign frame_ok = (frame_in == FRAME_PATTERN);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      slip_q   <= '0;
      match_q  <= '0;
      run_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      tp_q     <= '0;
    end else begin
      state_q  <= state_d;
      slip_q   <= slip_d;
      match_q  <= match_d;
      run_q    <= run_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      tp_q     <= tp_d;
    end
  end

  // start overrides whatever the current state would do with this cycle's word
  always_comb begin
    state_d  = state_q;
    slip_d   = slip_q;
    match_d  = match_q;
    run_d    = run_q;
    settle_d = settle_q;
    err_d    = err_q;
    if (start) begin
      state_d = CHECK;
      slip_d  = '0;
      match_d = '0;
      run_d   = '0;
    end else begin
      case (state_q)
        IDLE: ;
        CHECK: begin
          if (valid) begin
            if (frame_ok) begin
              match_d = MCW'(1);
              state_d = (MATCH_COUNT <= 1) ? LOCKED : VERIFY;
            end else if (slip_q == SLIP_MAX) begin
              state_d = FAIL;
            end else begin
              state_d = SLIP;
            end
          end
        end
        SLIP: begin
          if (slip_q != SLIP_MAX) slip_d = slip_q + SCW'(1);
          settle_d = SETTLE_INIT;
          state_d  = SETTLE;
        end
        SETTLE: begin
          if (settle_q == '0) begin
            state_d = CHECK;
          end else if (valid) begin
            settle_d = settle_q - STW'(1);
            if (settle_q == STW'(1)) state_d = CHECK;
          end
        end
        VERIFY: begin
          if (valid) begin
            if (frame_ok) begin
              match_d = match_q + MCW'(1);
              if (match_q + MCW'(1) >= MATCH_MAX) state_d = LOCKED;
            end else begin
              state_d = CHECK;
            end
          end
        end
        LOCKED: begin
          if (valid) begin
            if (frame_ok) begin
              run_d = '0;
            end else begin
              if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
              run_d = run_q + RCW'(1);
              if (run_q + RCW'(1) >= RUN_MAX) begin
                if (AUTO_RELOCK) begin
                  state_d = CHECK;
                  slip_d  = '0;
                  match_d = '0;
                  run_d   = '0;
                end else begin
                  state_d = FAIL;
                end
              end
            end
          end
        end
        FAIL: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    tp_d = tp_q;
    if (state_q == LOCKED && tp_en) begin
      if (valid) begin
        for (int i = 0; i < N_CH; i++) begin
          tp_d[i] = (data_in[i*2*S +: 2*S] == TP);
        end
      end
    end else begin
      tp_d = '0;
    end
  end

  assign bitslip  = (state_q == SLIP);
  assign locked   = (state_q == LOCKED);
  assign fail     = (state_q == FAIL);
  assign slip_cnt = slip_q;
  assign tp_ok    = tp_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_ltc_frame_aligner.sv
// tb/tb_ltc_frame_aligner.sv - self-checking bench for ltc_frame_aligner with an ISERDES rotation model.
module tb_ltc_frame_aligner;

  localparam int S = 8;
  localparam int N_CH = 2;
  localparam int SETTLE_CYCLES = 4;
  localparam int MATCH_COUNT = 16;
  localparam logic [15:0] TP = 16'h3DDA;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  frame_in = 8'h00;
  logic [31:0] data_in = 32'h0;
  logic        tp_en = 1'b0;
  logic        bitslip;
  logic        locked;
  logic        fail;
  logic [3:0]  slip_cnt;
  logic [1:0]  tp_ok;
  logic [15:0] err_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int model_slips = 0;
  int slip_base = 0;
  int slip_cycles[$];
  logic [1:0] tp_sb[$];
  logic [7:0] base = 8'h1E;
  bit force_bad = 1'b0;
  int exp_err = 0;

  ltc_frame_aligner dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .valid(valid),
    .frame_in(frame_in), .data_in(data_in), .tp_en(tp_en), .bitslip(bitslip),
    .locked(locked), .fail(fail), .slip_cnt(slip_cnt), .tp_ok(tp_ok), .err_cnt(err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = x;
    for (int k = 0; k < (n % 8); k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // frame lane follows the number of bitslips seen since slip_base
  task automatic tick();
    frame_in = force_bad ? 8'h00 : rotl(base, model_slips - slip_base);
    @(posedge sys_clk);
    #1;
    cyc++;
    if (bitslip) begin
      model_slips++;
      slip_cycles.push_back(cyc);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max_cycles; k++) begin
      if (locked || fail) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (locked || fail) ok = 1'b1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) tick();
    checks++; if ({bitslip, locked, fail} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b want=000", {bitslip, locked, fail}); end
    checks++; if (slip_cnt !== 4'd0) begin errors++; $display("FAIL reset_slip_cnt got=%0d want=0", slip_cnt); end
    checks++; if ({tp_ok, err_cnt} !== 18'd0) begin errors++; $display("FAIL reset_tp_err got=%h want=0", {tp_ok, err_cnt}); end
    sys_rst_n = 1'b1;
    repeat (2) tick();
    checks++; if (locked !== 1'b0 || bitslip !== 1'b0) begin errors++; $display("FAIL idle_no_start got=%b%b want=00", locked, bitslip); end
  endtask

  task automatic test_slip_align();
    bit ok;
    int lock_cyc;
    base = 8'h1E; slip_base = model_slips; slip_cycles.delete(); valid = 1'b1;
    pulse_start();
    wait_done(300, ok);
    lock_cyc = cyc;
    checks++; if (!ok || locked !== 1'b1 || fail !== 1'b0) begin errors++; $display("FAIL align_lock got locked=%b fail=%b want 1 0", locked, fail); end
    checks++; if (slip_cnt !== 4'd3) begin errors++; $display("FAIL align_slip_cnt got=%0d want=3", slip_cnt); end
    checks++; if (slip_cycles.size() != 3) begin errors++; $display("FAIL align_pulses got=%0d want=3", slip_cycles.size()); end
    if (slip_cycles.size() == 3) begin
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (slip_cycles[k] - slip_cycles[k-1] != SETTLE_CYCLES + 2) begin
          errors++; $display("FAIL align_gap%0d got=%0d want=%0d", k, slip_cycles[k] - slip_cycles[k-1], SETTLE_CYCLES + 2);
        end
      end
      checks++;
      if (lock_cyc - slip_cycles[2] != 1 + SETTLE_CYCLES + MATCH_COUNT) begin
        errors++; $display("FAIL align_latency got=%0d want=%0d", lock_cyc - slip_cycles[2], 1 + SETTLE_CYCLES + MATCH_COUNT);
      end
    end
  endtask

  task automatic test_aligned();
    int s0;
    base = 8'hF0; slip_base = model_slips; s0 = model_slips;
    pulse_start();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL restart_drops_lock got=%b want=0", locked); end
    repeat (MATCH_COUNT - 1) tick();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL aligned_early got=%b want=0", locked); end
    tick();
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL aligned_lock got=%b want=1", locked); end
    checks++; if (slip_cnt !== 4'd0 || model_slips != s0) begin errors++; $display("FAIL aligned_no_slip got cnt=%0d pulses=%0d want 0 0", slip_cnt, model_slips - s0); end
  endtask

  task automatic test_fail();
    bit ok;
    int s0;
    base = 8'h00; slip_base = model_slips; s0 = model_slips;
    pulse_start();
    wait_done(300, ok);
    checks++; if (!ok || fail !== 1'b1 || locked !== 1'b0) begin errors++; $display("FAIL stuck_fail got fail=%b locked=%b want 1 0", fail, locked); end
    checks++; if (model_slips - s0 != 8 || slip_cnt !== 4'd8) begin errors++; $display("FAIL stuck_slips got pulses=%0d cnt=%0d want 8 8", model_slips - s0, slip_cnt); end
    repeat (5) tick();
    checks++; if (fail !== 1'b1) begin errors++; $display("FAIL fail_holds got=%b want=1", fail); end
    base = 8'hF0; slip_base = model_slips;
    pulse_start();
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL fail_clears got=%b want=0", fail); end
    wait_done(300, ok);
    checks++; if (!ok || locked !== 1'b1) begin errors++; $display("FAIL relock_after_fail got=%b want=1", locked); end
  endtask

  task automatic test_relock();
    bit ok;
    force_bad = 1'b1;
    repeat (3) tick();
    force_bad = 1'b0;
    tick();
    exp_err = exp_err + 3;
    checks++; if (err_cnt !== 16'(exp_err)) begin errors++; $display("FAIL err_cnt_3 got=%0d want=%0d", err_cnt, exp_err); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_kept got=%b want=1", locked); end
    force_bad = 1'b1;
    repeat (3) tick();
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_before_limit got=%b want=1", locked); end
    tick();
    force_bad = 1'b0;
    exp_err = exp_err + 4;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_lost got=%b want=0", locked); end
    wait_done(300, ok);
    checks++; if (!ok || locked !== 1'b1 || slip_cnt !== 4'd0) begin errors++; $display("FAIL auto_relock got locked=%b cnt=%0d want 1 0", locked, slip_cnt); end
    checks++; if (err_cnt !== 16'(exp_err)) begin errors++; $display("FAIL err_cnt_7 got=%0d want=%0d", err_cnt, exp_err); end
  endtask

  task automatic test_tp();
    logic [31:0] pats[5];
    logic [1:0] exp;
    logic [1:0] got_exp;
    pats[0] = {16'h3DDB, 16'h3DDA};
    pats[1] = {16'h3DDA, 16'h3DDA};
    pats[2] = {16'h0000, 16'h3DDB};
    pats[3] = {16'h3DDA, 16'h1234};
    pats[4] = {16'h3DDA, 16'h3DDA};
    tp_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) tp_en = 1'b0;
      data_in = pats[k % 5];
      exp[0] = tp_en && (data_in[15:0] == TP);
      exp[1] = tp_en && (data_in[31:16] == TP);
      tp_sb.push_back(exp);
      tick();
      checks++;
      if (tp_sb.size() == 0) begin
        errors++; $display("FAIL tp_sb_empty step=%0d", k);
      end else begin
        got_exp = tp_sb.pop_front();
        if (tp_ok !== got_exp) begin errors++; $display("FAIL tp_ok%0d got=%b want=%b", k, tp_ok, got_exp); end
      end
    end
    data_in = 32'h0;
  endtask

  task automatic test_reset_settle();
    int s0;
    int guard;
    base = 8'h1E; slip_base = model_slips;
    pulse_start();
    guard = 0;
    while (!bitslip && guard < 50) begin tick(); guard++; end
    checks++; if (!bitslip) begin errors++; $display("FAIL settle_reach got=%b want=1", bitslip); end
    repeat (2) tick();
    #2;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({bitslip, locked, fail, slip_cnt, tp_ok, err_cnt} !== 25'd0) begin
      errors++; $display("FAIL async_reset got=%h want=0", {bitslip, locked, fail, slip_cnt, tp_ok, err_cnt});
    end
    tick();
    sys_rst_n = 1'b1;
    s0 = model_slips;
    repeat (20) tick();
    checks++; if (model_slips != s0 || locked !== 1'b0 || slip_cnt !== 4'd0) begin errors++; $display("FAIL post_reset_idle got pulses=%0d locked=%b want 0 0", model_slips - s0, locked); end
  endtask

  initial begin
    test_reset();
    test_slip_align();
    test_aligned();
    test_fail();
    test_relock();
    test_tp();
    test_reset_settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
